// File: rtl/vqe_screening_scheduler.sv
// ---------------------------------------------------------------------------
// vqe_screening_scheduler
//
// Runs a screening campaign over the masked MOF-74 metal candidates
// (0..5 = Mg, Fe, Co, Ni, Cu, Zn). For each enabled candidate it launches
// one VQE simulation and counts energy-measurement pulses until the run is
// complete. It keeps the best accepted candidate, ranked by catalyst score
// with stability as the tie-break.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start                  begin a campaign (only honoured while idle)
//   abort                  terminate the running campaign
//   material_mask[5:0]     bit i enables candidate i, latched on start
//   vqe_hamiltonian_ready  one-cycle launch strobe to the VQE
//   vqe_material_sel[2:0]  candidate currently being simulated
//   vqe_energy_ready       one-cycle measurement pulse from the VQE
//   vqe_ground_energy      ground-state energy, valid with the pulse
//   vqe_catalyst_score     IEEE-754 single, valid with the pulse
//   vqe_stability          IEEE-754 single, valid with the pulse
//   busy                   campaign in progress
//   done                   one-cycle pulse at normal completion
//   aborted                one-cycle pulse when a campaign is aborted
//   timeout_err            sticky run-timeout flag, cleared on start
//   best_valid             at least one result was accepted
//   best_material/score/stability/energy   best candidate so far
//   runs_completed         runs finished without timeout this campaign
// ---------------------------------------------------------------------------
module vqe_screening_scheduler #(
   parameter int NUM_MATERIALS = 6,
   parameter int MEAS_PER_RUN  = 10,
   parameter int SETTLE_CYCLES = 2,
   parameter int TIMEOUT       = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [5:0]  material_mask,
   output logic        vqe_hamiltonian_ready,
   output logic [2:0]  vqe_material_sel,
   input  logic        vqe_energy_ready,
   input  logic [31:0] vqe_ground_energy,
   input  logic [31:0] vqe_catalyst_score,
   input  logic [31:0] vqe_stability,
   output logic        busy,
   output logic        done,
   output logic        aborted,
   output logic        timeout_err,
   output logic        best_valid,
   output logic [2:0]  best_material,
   output logic [31:0] best_score,
   output logic [31:0] best_stability,
   output logic [31:0] best_energy,
   output logic [2:0]  runs_completed
);

   localparam int MW = $clog2(MEAS_PER_RUN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   localparam logic [MW-1:0] MEAS_LAST   = MW'(MEAS_PER_RUN - 1);
   localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      LAUNCH,
      WAIT_MEAS,
      SETTLE,
      DONE
   } state_t;

   state_t        state;
   logic [5:0]    mask_q;
   logic [3:0]    ptr;
   logic [MW-1:0] meas_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [SW-1:0] settle_cnt;

   logic          scan_found;
   logic [2:0]    scan_idx;
   logic          sample_ok;
   logic          sample_better;

   // Priority search for the lowest enabled candidate at or above the
   // pointer. Walking downwards lets the lowest match overwrite the others.
   always_comb begin
      scan_found = 1'b0;
      scan_idx   = 3'd0;
      for (int i = NUM_MATERIALS - 1; i >= 0; i--) begin
         if (mask_q[i] && (4'(i) >= ptr)) begin
            scan_found = 1'b1;
            scan_idx   = 3'(i);
         end
      end
   end

   // Positive IEEE-754 singles order like unsigned integers, so the
   // concatenation {score, stability} ranks by score first, then stability.
   // Strictly-greater keeps the lower index on a tie since candidates are
   // visited in ascending order.
   always_comb begin
      sample_ok     = ~vqe_catalyst_score[31] & ~vqe_stability[31];
      sample_better = ~best_valid |
                      ({vqe_catalyst_score, vqe_stability} >
                       {best_score, best_stability});
   end

   // Campaign sequencer. Strobes default low every cycle so each one is a
   // single-cycle pulse. The timeout counter restarts at 1 on a launch or a
   // pulse, so it equals the number of cycles elapsed since that event, and
   // the timeout is taken in the cycle before it would reach TIMEOUT; this
   // makes timeout_err visible exactly TIMEOUT cycles after the last event.
   // Abort is checked before the state case so it wins over any transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state                 <= IDLE;
         mask_q                <= 6'd0;
         ptr                   <= 4'd0;
         meas_cnt              <= '0;
         tmo_cnt               <= '0;
         settle_cnt            <= '0;
         vqe_hamiltonian_ready <= 1'b0;
         vqe_material_sel      <= 3'd0;
         busy                  <= 1'b0;
         done                  <= 1'b0;
         aborted               <= 1'b0;
         timeout_err           <= 1'b0;
         best_valid            <= 1'b0;
         best_material         <= 3'd0;
         best_score            <= 32'd0;
         best_stability        <= 32'd0;
         best_energy           <= 32'd0;
         runs_completed        <= 3'd0;
      end else begin
         vqe_hamiltonian_ready <= 1'b0;
         done                  <= 1'b0;
         aborted               <= 1'b0;

         if (abort && (state != IDLE)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     mask_q         <= material_mask;
                     ptr            <= 4'd0;
                     best_valid     <= 1'b0;
                     best_material  <= 3'd0;
                     best_score     <= 32'd0;
                     best_stability <= 32'd0;
                     best_energy    <= 32'd0;
                     runs_completed <= 3'd0;
                     timeout_err    <= 1'b0;
                     busy           <= 1'b1;
                     state          <= SCAN;
                  end
               end

               SCAN: begin
                  if (scan_found) begin
                     vqe_material_sel      <= scan_idx;
                     vqe_hamiltonian_ready <= 1'b1;
                     state                 <= LAUNCH;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end

               LAUNCH: begin
                  meas_cnt <= '0;
                  tmo_cnt  <= TW'(1);
                  state    <= WAIT_MEAS;
               end

               WAIT_MEAS: begin
                  if (vqe_energy_ready) begin
                     tmo_cnt <= TW'(1);
                     if (meas_cnt == MEAS_LAST) begin
                        runs_completed <= runs_completed + 3'd1;
                        if (sample_ok && sample_better) begin
                           best_valid     <= 1'b1;
                           best_material  <= vqe_material_sel;
                           best_score     <= vqe_catalyst_score;
                           best_stability <= vqe_stability;
                           best_energy    <= vqe_ground_energy;
                        end
                        settle_cnt <= '0;
                        state      <= SETTLE;
                     end else begin
                        meas_cnt <= meas_cnt + MW'(1);
                     end
                  end else if (tmo_cnt == TMO_LAST) begin
                     timeout_err <= 1'b1;
                     settle_cnt  <= '0;
                     state       <= SETTLE;
                  end else begin
                     tmo_cnt <= tmo_cnt + TW'(1);
                  end
               end

               SETTLE: begin
                  if (settle_cnt == SETTLE_LAST) begin
                     ptr   <= {1'b0, vqe_material_sel} + 4'd1;
                     state <= SCAN;
                  end else begin
                     settle_cnt <= settle_cnt + SW'(1);
                  end
               end

               DONE: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vqe_screening_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vqe_screening_scheduler
//
// Self-checking bench for vqe_screening_scheduler. A behavioural VQE model
// answers every launch strobe with a configurable number of measurement
// pulses. Whole campaigns are described as table records and compared with
// hand-derived results, corner-case timing is covered by short hand-written
// sequences, and random campaigns are compared with a campaign-level model.
// ---------------------------------------------------------------------------
module tb_vqe_screening_scheduler;

   localparam int MEAS = 10;
   localparam int TMO  = 64;

   localparam logic [31:0] F_0_125  = 32'h3E000000;
   localparam logic [31:0] F_0_25   = 32'h3E800000;
   localparam logic [31:0] F_0_375  = 32'h3EC00000;
   localparam logic [31:0] F_0_5    = 32'h3F000000;
   localparam logic [31:0] F_0_625  = 32'h3F200000;
   localparam logic [31:0] F_0_6875 = 32'h3F300000;
   localparam logic [31:0] F_0_75   = 32'h3F400000;
   localparam logic [31:0] F_0_875  = 32'h3F600000;
   localparam logic [31:0] F_0_9    = 32'h3F666666;
   localparam logic [31:0] F_1      = 32'h3F800000;
   localparam logic [31:0] F_NEG_05 = 32'hBF000000;
   localparam logic [31:0] F_NEG_1  = 32'hBF800000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [5:0]  material_mask;
   logic        vqe_hamiltonian_ready;
   logic [2:0]  vqe_material_sel;
   logic        vqe_energy_ready;
   logic [31:0] vqe_ground_energy;
   logic [31:0] vqe_catalyst_score;
   logic [31:0] vqe_stability;
   logic        busy;
   logic        done;
   logic        aborted;
   logic        timeout_err;
   logic        best_valid;
   logic [2:0]  best_material;
   logic [31:0] best_score;
   logic [31:0] best_stability;
   logic [31:0] best_energy;
   logic [2:0]  runs_completed;

   vqe_screening_scheduler dut (
      .clk                   (clk),
      .reset                 (reset),
      .start                 (start),
      .abort                 (abort),
      .material_mask         (material_mask),
      .vqe_hamiltonian_ready (vqe_hamiltonian_ready),
      .vqe_material_sel      (vqe_material_sel),
      .vqe_energy_ready      (vqe_energy_ready),
      .vqe_ground_energy     (vqe_ground_energy),
      .vqe_catalyst_score    (vqe_catalyst_score),
      .vqe_stability         (vqe_stability),
      .busy                  (busy),
      .done                  (done),
      .aborted               (aborted),
      .timeout_err           (timeout_err),
      .best_valid            (best_valid),
      .best_material         (best_material),
      .best_score            (best_score),
      .best_stability        (best_stability),
      .best_energy           (best_energy),
      .runs_completed        (runs_completed)
   );

   always #5 clk = ~clk;

   // One campaign record: per-candidate VQE behaviour plus expected result.
   typedef struct {
      logic [5:0]       mask;
      logic [5:0][31:0] score;
      logic [5:0][31:0] stab;
      logic [5:0][3:0]  npulse;
      int               gap;
      logic             exp_valid;
      logic [2:0]       exp_mat;
      logic [31:0]      exp_score;
      logic [31:0]      exp_stab;
      logic [31:0]      exp_energy;
      logic [2:0]       exp_runs;
      logic             exp_tmo;
   } vec_t;

   vec_t vecs[8];

   // VQE model configuration
   logic [31:0] cfg_score [6];
   logic [31:0] cfg_stab [6];
   logic [31:0] cfg_energy [6];
   int          cfg_np [6];
   int          cfg_gap;
   int          vqe_m;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int abort_cnt = 0;
   int launch_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Observes launches and completion strobes mid-cycle.
   always @(negedge clk) begin
      if (vqe_hamiltonian_ready) launch_q.push_back(int'(vqe_material_sel));
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
   end

   // Behavioural VQE: after a launch, the first pulse lands in the next
   // cycle and further pulses follow every cfg_gap cycles. Data buses carry
   // junk outside pulses so late or early capture is visible.
   initial begin
      vqe_energy_ready   = 1'b0;
      vqe_ground_energy  = 32'd0;
      vqe_catalyst_score = 32'd0;
      vqe_stability      = 32'd0;
      forever begin
         @(negedge clk);
         if (vqe_hamiltonian_ready) begin
            vqe_m = int'(vqe_material_sel);
            @(negedge clk);
            for (int k = 0; k < cfg_np[vqe_m]; k++) begin
               if (k > 0) repeat (cfg_gap - 1) @(negedge clk);
               vqe_energy_ready   = 1'b1;
               vqe_ground_energy  = cfg_energy[vqe_m];
               vqe_catalyst_score = cfg_score[vqe_m];
               vqe_stability      = cfg_stab[vqe_m];
               @(negedge clk);
               vqe_energy_ready   = 1'b0;
               vqe_ground_energy  = $urandom;
               vqe_catalyst_score = $urandom;
               vqe_stability      = $urandom;
            end
         end
      end
   end

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic clear_monitor();
      launch_q.delete();
      done_cnt  = 0;
      abort_cnt = 0;
   endtask

   task automatic check_final(input string tag, input logic ev, input logic [2:0] em,
                              input logic [31:0] es, input logic [31:0] est,
                              input logic [31:0] ee, input logic [2:0] er,
                              input logic et);
      check_output({tag, "_best_valid"},  64'(best_valid),     64'(ev));
      check_output({tag, "_best_mat"},    64'(best_material),  64'(em));
      check_output({tag, "_best_score"},  64'(best_score),     64'(es));
      check_output({tag, "_best_stab"},   64'(best_stability), 64'(est));
      check_output({tag, "_best_energy"}, 64'(best_energy),    64'(ee));
      check_output({tag, "_runs"},        64'(runs_completed), 64'(er));
      check_output({tag, "_timeout_err"}, 64'(timeout_err),    64'(et));
   endtask

   // Launch order must be the enabled indices in ascending order.
   task automatic check_launches(input string tag, input logic [5:0] mask);
      int exp_q[$];
      bit same;
      for (int i = 0; i < 6; i++) if (mask[i]) exp_q.push_back(i);
      check_output({tag, "_launch_count"}, 64'(launch_q.size()), 64'(exp_q.size()));
      same = (launch_q.size() == exp_q.size());
      if (same) for (int i = 0; i < exp_q.size(); i++) if (launch_q[i] != exp_q[i]) same = 0;
      check_output({tag, "_launch_order"}, 64'(same), 64'd1);
   endtask

   task automatic load_vec(input int v);
      for (int i = 0; i < 6; i++) begin
         cfg_score[i]  = vecs[v].score[i];
         cfg_stab[i]   = vecs[v].stab[i];
         cfg_energy[i] = 32'hC1000000 + 32'(i);
         cfg_np[i]     = int'(vecs[v].npulse[i]);
      end
      cfg_gap = vecs[v].gap;
   endtask

   task automatic start_campaign(input logic [5:0] mask);
      clear_monitor();
      material_mask = mask;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      material_mask = 6'($urandom);
   endtask

   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int c = 0; c < 3000; c++) begin
         if (done) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      check_output({tag, "_done_seen"}, 64'(seen), 64'd1);
      @(negedge clk);
      check_output({tag, "_idle_after_done"}, 64'({busy, done}), 64'd0);
   endtask

   task automatic apply_stimulus(input int v);
      string tag;
      tag = $sformatf("vec%0d", v);
      load_vec(v);
      start_campaign(vecs[v].mask);
      wait_done(tag);
      check_final(tag, vecs[v].exp_valid, vecs[v].exp_mat, vecs[v].exp_score,
                  vecs[v].exp_stab, vecs[v].exp_energy, vecs[v].exp_runs,
                  vecs[v].exp_tmo);
      check_launches(tag, vecs[v].mask);
      check_output({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      repeat (4) @(negedge clk);
   endtask

   // Campaign-level reference: walk the enabled candidates, drop timed-out
   // ones, keep the first candidate of maximal {score, stability} among
   // those with both sign bits clear.
   task automatic run_random(input int n);
      logic [5:0]  mask;
      logic        ev, et;
      logic [2:0]  em, er;
      logic [31:0] es, est, ee;
      string       tag;
      tag = $sformatf("rnd%0d", n);
      for (int i = 0; i < 6; i++) begin
         cfg_score[i]  = $urandom;
         cfg_stab[i]   = $urandom;
         cfg_energy[i] = $urandom;
         if ($urandom_range(3) != 0) cfg_score[i][31] = 1'b0;
         if ($urandom_range(3) != 0) cfg_stab[i][31] = 1'b0;
         if (i > 0 && $urandom_range(3) == 0) begin
            int j;
            j = $urandom_range(i - 1);
            cfg_score[i] = cfg_score[j];
            cfg_stab[i]  = cfg_stab[j];
         end
         cfg_np[i] = ($urandom_range(7) == 0) ? int'($urandom_range(9, 1)) : MEAS;
      end
      cfg_gap = int'($urandom_range(3, 1));
      mask = 6'($urandom);
      ev = 0; et = 0; em = 0; er = 0; es = 0; est = 0; ee = 0;
      for (int i = 0; i < 6; i++) begin
         if (!mask[i]) continue;
         if (cfg_np[i] < MEAS) begin
            et = 1;
            continue;
         end
         er = er + 3'd1;
         if (cfg_score[i][31] || cfg_stab[i][31]) continue;
         if (!ev || ({cfg_score[i], cfg_stab[i]} > {es, est})) begin
            ev = 1; em = 3'(i); es = cfg_score[i]; est = cfg_stab[i]; ee = cfg_energy[i];
         end
      end
      start_campaign(mask);
      wait_done(tag);
      check_final(tag, ev, em, es, est, ee, er, et);
      check_launches(tag, mask);
      repeat (4) @(negedge clk);
   endtask

   // Global time bound so the bench always ends.
   initial begin
      #5ms;
      failures++;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c0;
      bit seen;

      // Table of whole campaigns; packed lists run index 5 (Zn) .. 0 (Mg).
      vecs[0] = '{6'b111111,
                  {F_0_25, F_0_6875, F_0_625, F_0_875, F_0_75, F_0_5},
                  {F_1, F_0_5, F_1, F_0_375, F_0_75, F_1},
                  {6{4'd10}}, 1,
                  1'b1, 3'd2, F_0_875, F_0_375, 32'hC1000002, 3'd6, 1'b0};
      vecs[1] = '{6'b001001, {6{F_0_5}}, {6{F_1}}, {6{4'd10}}, 2,
                  1'b1, 3'd0, F_0_5, F_1, 32'hC1000000, 3'd2, 1'b0};
      vecs[2] = '{6'b000010, {6{F_0_5}}, {6{F_1}}, {6{4'd4}}, 1,
                  1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b1};
      vecs[3] = '{6'b000000, {6{F_0_5}}, {6{F_1}}, {6{4'd10}}, 1,
                  1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0};
      vecs[4] = '{6'b000011, {F_0_5, F_0_5, F_0_5, F_0_5, F_0_25, F_NEG_05},
                  {F_1, F_1, F_1, F_1, F_0_5, F_1}, {6{4'd10}}, 3,
                  1'b1, 3'd1, F_0_25, F_0_5, 32'hC1000001, 3'd2, 1'b0};
      vecs[5] = '{6'b000101, {F_0_5, F_0_5, F_0_5, F_0_125, F_1, F_0_9},
                  {F_1, F_1, F_1, F_0_5, F_1, F_NEG_1}, {6{4'd10}}, 2,
                  1'b1, 3'd2, F_0_125, F_0_5, 32'hC1000002, 3'd2, 1'b0};
      vecs[6] = '{6'b100001, {F_0_25, F_0_5, F_0_5, F_0_5, F_0_5, F_0_875},
                  {6{F_1}}, {4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd4}, 1,
                  1'b1, 3'd5, F_0_25, F_1, 32'hC1000005, 3'd1, 1'b1};
      vecs[7] = '{6'b000110, {6{F_0_75}}, {F_1, F_1, F_1, F_0_875, F_0_75, F_1},
                  {6{4'd11}}, 1,
                  1'b1, 3'd2, F_0_75, F_0_875, 32'hC1000002, 3'd2, 1'b0};

      reset = 1'b1; start = 1'b0; abort = 1'b0; material_mask = 6'd0;
      load_vec(0);
      repeat (3) @(negedge clk);
      check_output("reset_strobes", 64'({vqe_hamiltonian_ready, done, aborted, busy}), 64'd0);
      check_output("reset_flags", 64'({timeout_err, best_valid, runs_completed, vqe_material_sel}), 64'd0);
      check_output("reset_best", 64'({best_score, best_energy}), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 8; v++) apply_stimulus(v);

      // Start/launch latency, start while busy, best update timing, spacing.
      $display("[TB] sequence: start timing and launch spacing");
      load_vec(0);
      start_campaign(6'b111111);
      check_output("t1_busy", 64'(busy), 64'd1);
      check_output("t1_no_launch", 64'(vqe_hamiltonian_ready), 64'd0);
      @(negedge clk);
      check_output("t2_launch", 64'(vqe_hamiltonian_ready), 64'd1);
      check_output("t2_sel", 64'(vqe_material_sel), 64'd0);
      c0 = cyc;
      material_mask = 6'b000001;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < c0 + 10) @(negedge clk);
      check_output("last_pulse_no_update", 64'(best_valid), 64'd0);
      @(negedge clk);
      check_output("update_after_last_pulse", 64'({best_valid, best_material, best_score}),
                   64'({1'b1, 3'd0, F_0_5}));
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (vqe_hamiltonian_ready) begin
            seen = 1;
            break;
         end
      end
      check_output("second_launch_spacing", 64'(seen ? cyc - c0 : -1), 64'd14);
      check_output("second_launch_sel", 64'(vqe_material_sel), 64'd1);
      wait_done("busy_start");
      check_final("busy_start", 1'b1, 3'd2, F_0_875, F_0_375, 32'hC1000002, 3'd6, 1'b0);
      check_launches("busy_start", 6'b111111);
      repeat (4) @(negedge clk);

      // Empty mask: done two cycles after start, then idle.
      $display("[TB] sequence: empty mask");
      start_campaign(6'b000000);
      check_output("empty_t1", 64'({busy, done}), 64'b10);
      @(negedge clk);
      check_output("empty_t2_done", 64'({busy, done}), 64'b11);
      @(negedge clk);
      check_output("empty_t3_idle", 64'({busy, done}), 64'b00);
      check_output("empty_no_launch", 64'(launch_q.size()), 64'd0);
      repeat (2) @(negedge clk);

      // Timeout flag appears exactly TMO cycles after the fourth pulse.
      $display("[TB] sequence: timeout timing");
      load_vec(2);
      start_campaign(6'b000010);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         if (vqe_hamiltonian_ready) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      check_output("tmo_launch_seen", 64'(seen), 64'd1);
      c0 = cyc;
      while (cyc < c0 + 4 + TMO - 1) @(negedge clk);
      check_output("tmo_before", 64'(timeout_err), 64'd0);
      @(negedge clk);
      check_output("tmo_at", 64'(timeout_err), 64'd1);
      wait_done("tmo");
      check_output("tmo_result", 64'({best_valid, runs_completed}), 64'd0);
      repeat (4) @(negedge clk);

      // Abort during the candidate 3 run keeps partial results.
      $display("[TB] sequence: abort");
      load_vec(0);
      start_campaign(6'b111111);
      seen = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (vqe_hamiltonian_ready && vqe_material_sel == 3'd3) begin
            seen = 1;
            break;
         end
      end
      check_output("abort_cand3_launch", 64'(seen), 64'd1);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_output("abort_pulse", 64'({aborted, busy}), 64'b10);
      @(negedge clk);
      check_output("abort_pulse_end", 64'(aborted), 64'd0);
      check_final("abort", 1'b1, 3'd2, F_0_875, F_0_375, 32'hC1000002, 3'd3, 1'b0);
      repeat (20) @(negedge clk);
      check_output("abort_counts", 64'({done_cnt[7:0], abort_cnt[7:0]}), 64'h0001);

      // Synchronous reset in mid-campaign returns everything to zero.
      $display("[TB] sequence: reset mid-campaign");
      start_campaign(6'b111111);
      repeat (19) @(negedge clk);
      check_output("pre_reset_valid", 64'(best_valid), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_output("mid_reset_state", 64'({busy, best_valid, runs_completed, vqe_material_sel}), 64'd0);
      check_output("mid_reset_best", 64'({best_score, best_energy}), 64'd0);
      repeat (15) @(negedge clk);
      check_output("mid_reset_no_pulses", 64'({done_cnt[7:0], abort_cnt[7:0]}), 64'd0);

      for (int n = 0; n < 12; n++) run_random(n);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vqe_screening_scheduler.md
# vqe_screening_scheduler

Sequencer that drives the VQE processor through a screening campaign over a masked set of MOF-74 metal candidates (Mg, Fe, Co, Ni, Cu, Zn).

- Per candidate, it launches one simulation and counts the energy-measurement pulses until the run completes.
- It tracks the best candidate by catalyst score, with stability as tie-break.
- It sits between the top-level battery-chemistry controller and the VQE processor, and owns the VQE's `hamiltonian_ready` strobe.

## Interface
Parameters:
- NUM_MATERIALS, 6: candidate count; indices 0..5 = Mg, Fe, Co, Ni, Cu, Zn.
- MEAS_PER_RUN, 10: `vqe_energy_ready` pulses that constitute one complete run.
- SETTLE_CYCLES, 2: idle cycles after a run before the next launch.
- TIMEOUT, 64: maximum cycles between launch/pulse and the next pulse.

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin campaign; sampled only in IDLE
- abort  in  1  terminate campaign
- material_mask  in  6  bit i enables candidate i; sampled on accepted start
- vqe_hamiltonian_ready  out  1  one-cycle launch strobe to VQE
- vqe_material_sel  out  3  index of current candidate, stable for whole run
- vqe_energy_ready  in  1  one-cycle measurement pulse from VQE
- vqe_ground_energy  in  32  ground-state energy, valid with pulse
- vqe_catalyst_score  in  32  IEEE-754 single, valid with pulse
- vqe_stability  in  32  IEEE-754 single, valid with pulse
- busy  out  1  campaign in progress
- done  out  1  one-cycle pulse at campaign completion
- aborted  out  1  one-cycle pulse on abort
- timeout_err  out  1  sticky; set by any run timeout, cleared on accepted start
- best_valid  out  1  at least one candidate produced an accepted result
- best_material  out  3  index of best candidate
- best_score  out  32  catalyst score of best candidate
- best_stability  out  32  stability of best candidate
- best_energy  out  32  ground energy of best candidate
- runs_completed  out  3  candidates finished without timeout this campaign

## Operation
- States: IDLE, SCAN, LAUNCH, WAIT_MEAS, SETTLE, DONE.
- IDLE: start=1 latches mask, clears best_*, runs_completed and timeout_err, sets candidate pointer to 0, then goes to SCAN.
- SCAN: finds the lowest enabled index ≥ pointer.
  - Found: sets vqe_material_sel and goes to LAUNCH.
  - None: goes to DONE.
- LAUNCH: asserts vqe_hamiltonian_ready for exactly one cycle, clears the pulse and timeout counters, then goes to WAIT_MEAS.
- WAIT_MEAS: each vqe_energy_ready pulse increments the pulse count, captures the three VQE data words, and clears the timeout counter.
  - When the count reaches MEAS_PER_RUN, the last captured sample is evaluated and the FSM goes to SETTLE.
- Evaluation: a sample is accepted only if the sign bits of both score and stability are 0.
  - Merit is the 64-bit unsigned value {score, stability}; valid because positive floats order as unsigned integers.
  - The candidate replaces best_* if best_valid=0 or its merit is strictly greater; ties keep the lower index.
  - runs_completed increments on every completed run, accepted or not.
- Timeout: if the timeout counter reaches TIMEOUT in WAIT_MEAS, timeout_err is set and the candidate is skipped without evaluation; the FSM goes to SETTLE.
- SETTLE: waits SETTLE_CYCLES cycles, sets pointer = current index + 1, then goes to SCAN.
- DONE: pulses done for one cycle, clears busy, then goes to IDLE.
- busy = 1 in every state except IDLE.
- abort=1 in any non-IDLE state: next state is IDLE, aborted pulses, done is not pulsed; best_* and runs_completed hold their partial values.
- abort has priority over every same-cycle transition.

## Timing
- Reset values: all outputs 0; FSM in IDLE.
- start in cycle t (IDLE) → busy=1 at t+1; first vqe_hamiltonian_ready at t+2 (SCAN takes one cycle).
- A vqe_energy_ready pulse arriving in the launch cycle itself is ignored.
- best_* update in the cycle after the MEAS_PER_RUN-th pulse.
- Launch spacing between consecutive enabled candidates = 1 (SETTLE exit) + SETTLE_CYCLES + 1 (SCAN) after the final pulse.
- material_mask = 0 → DONE at t+2, done pulse at t+2, best_valid=0.
- start while busy: ignored.
- Pulses in SETTLE or SCAN: ignored.
- Pulses beyond MEAS_PER_RUN: never counted.
- reset mid-campaign: all state returns to reset values in the next cycle; no done or aborted pulse.

## Test plan
- Mask 6'b111111, VQE model emitting 10 pulses per launch with Mg=0.5/1.0, Fe=0.75/0.75, Co=0.875/0.375, Ni=0.625/1.0, Cu=0.6875/0.5, Zn=0.25/1.0 → 6 launches, done pulse, best_material=2, best_score=32'h3F600000, runs_completed=6.
- Mask 6'b001001 (Mg, Ni), equal scores 0.5 with stability 1.0 → tie keeps lower index: best_material=0.
- Mask 6'b000010, VQE stops after 4 pulses → timeout_err=1 TIMEOUT cycles after the 4th pulse, best_valid=0, done pulses, runs_completed=0.
- Mask 6'b000000 → done two cycles after start, no vqe_hamiltonian_ready.
- abort asserted mid-WAIT_MEAS of candidate 3 → aborted pulse, busy=0 next cycle, best_* retains candidate 0–2 result, no done pulse.
- Sample with negative score (32'hBF000000) → rejected; a start asserted while busy is ignored.
